// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and constants for the instruction-fetch sequencer.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

    localparam int PC_W  = 16;
    localparam int SEL_W = 5;

    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    localparam logic [1:0] BR_PCI = 2'b00;
    localparam logic [1:0] BR_I0  = 2'b01;
    localparam logic [1:0] BR_R0  = 2'b10;

    // Bit positions inside the select vector, MSB first.
    localparam int SEL_RESET = 4;
    localparam int SEL_PC1   = 3;
    localparam int SEL_PCI   = 2;
    localparam int SEL_I0    = 1;
    localparam int SEL_R0    = 0;

endpackage
`default_nettype wire

// File: rtl/fetch_sel_decode.sv
`default_nettype none
// ============================================================================
// Module : fetch_sel_decode
// Brief  : Combinational decode of FSM state and branch request into the
//          address-logic mode selects (one-hot or all zero).
// Rev    : 1.0
// ============================================================================
module fetch_sel_decode
    import fetch_pkg::*;
(
    input  fetch_state_t     state,
    input  logic             branch_req,
    input  logic             instr_ready,
    input  logic [1:0]       branch_mode,
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        sel = '0;
        case (state)
            ST_RST: sel[SEL_RESET] = 1'b1;
            ST_HOLD: begin
                if (branch_req) begin
                    case (branch_mode)
                        BR_PCI:  sel[SEL_PCI] = 1'b1;
                        BR_I0:   sel[SEL_I0]  = 1'b1;
                        BR_R0:   sel[SEL_R0]  = 1'b1;
                        default: sel[SEL_PC1] = 1'b1;
                    endcase
                end else if (instr_ready) begin
                    sel[SEL_PC1] = 1'b1;
                end
            end
            default: sel = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fetch_sequencer
// Brief  : Instruction-fetch controller owning the PC; drives the shared
//          address adder and a req/ack + rvalid instruction memory.
//          FETCH_PERF_CNT_EN enables the saturating fetch/redirect counters.
// Rev    : 1.0
// ============================================================================
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int INSTR_W     = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    PCside,
    output logic [7:0]         Iside,
    output logic [PC_W-1:0]    Rside,
    output logic               ResetPC,
    output logic               PCplus1,
    output logic               PCplusI,
    output logic               Iplus0,
    output logic               Rplus0,
    input  logic [PC_W-1:0]    ALout,
    output logic               MemReq,
    output logic [PC_W-1:0]    MemAddr,
    input  logic               MemAck,
    input  logic               MemRvalid,
    input  logic [INSTR_W-1:0] MemRdata,
    output logic               InstrValid,
    input  logic               InstrReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    InstrPC,
    input  logic               BranchReq,
    input  logic [1:0]         BranchMode,
    input  logic [7:0]         BranchImm,
    input  logic [PC_W-1:0]    BranchReg,
    output logic               BranchAck,
    output logic               FetchErr,
    output logic [15:0]        FetchCount,
    output logic [15:0]        RedirCount
);

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    fetch_state_t     state;
    logic [PC_W-1:0]  pc;
    logic [7:0]       tcnt;
    logic [SEL_W-1:0] sel;
    logic             timeout;
    logic             hold_exit;
    logic             br_take;

    fetch_sel_decode u_sel_decode (
        .state       (state),
        .branch_req  (BranchReq),
        .instr_ready (InstrReady),
        .branch_mode (BranchMode),
        .sel         (sel)
    );

    assign {ResetPC, PCplus1, PCplusI, Iplus0, Rplus0} = sel;

    assign PCside     = pc;
    assign Iside      = BranchImm;
    assign Rside      = BranchReg;
    assign MemReq     = (state == ST_REQ);
    assign MemAddr    = pc;
    assign InstrValid = (state == ST_HOLD);
    assign br_take    = InstrValid & BranchReq;
    assign BranchAck  = br_take;
    assign hold_exit  = InstrValid & (BranchReq | InstrReady);
    assign timeout    = (MEM_TIMEOUT != 0) && (state == ST_WAIT) &&
                        !MemRvalid && (tcnt == TO_LAST);
    assign FetchErr   = timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RST;
            pc      <= '0;
            Instr   <= '0;
            InstrPC <= '0;
            tcnt    <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    pc    <= ALout;
                    state <= ST_REQ;
                end
                ST_REQ: begin
                    if (MemAck) begin
                        tcnt  <= '0;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (MemRvalid) begin
                        Instr   <= MemRdata;
                        InstrPC <= pc;
                        state   <= ST_HOLD;
                    end else if (timeout) begin
                        // Re-issue the same PC; a straggling rvalid lands in REQ and is dropped.
                        state <= ST_REQ;
                    end else if (tcnt != 8'hFF) begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                ST_HOLD: begin
                    if (hold_exit) begin
                        pc    <= ALout;
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_RST;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] redir_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            redir_cnt <= '0;
        end else begin
            if (hold_exit && (fetch_cnt != 16'hFFFF)) fetch_cnt <= fetch_cnt + 16'd1;
            if (br_take && (redir_cnt != 16'hFFFF))   redir_cnt <= redir_cnt + 16'd1;
        end
    end

    assign FetchCount = fetch_cnt;
    assign RedirCount = redir_cnt;
`else
    assign FetchCount = '0;
    assign RedirCount = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_sequencer
// Brief  : Directed + randomized bench for fetch_sequencer with a PC model.
// Rev    : 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] PCside, Rside, ALout, MemAddr, Instr, InstrPC, BranchReg, MemRdata;
    logic [7:0]  Iside, BranchImm;
    logic        ResetPC, PCplus1, PCplusI, Iplus0, Rplus0;
    logic        MemReq, MemAck, MemRvalid, InstrValid, InstrReady;
    logic        BranchReq, BranchAck, FetchErr;
    logic [1:0]  BranchMode;
    logic [15:0] FetchCount, RedirCount;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_pc;
    logic [15:0] last_data;
    logic [15:0] exp_fcnt;
    logic [15:0] exp_rcnt;

    always #5 clk = ~clk;

    fetch_sequencer #(.INSTR_W(16), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .PCside(PCside), .Iside(Iside), .Rside(Rside),
        .ResetPC(ResetPC), .PCplus1(PCplus1), .PCplusI(PCplusI),
        .Iplus0(Iplus0), .Rplus0(Rplus0), .ALout(ALout),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
        .MemRvalid(MemRvalid), .MemRdata(MemRdata),
        .InstrValid(InstrValid), .InstrReady(InstrReady),
        .Instr(Instr), .InstrPC(InstrPC),
        .BranchReq(BranchReq), .BranchMode(BranchMode),
        .BranchImm(BranchImm), .BranchReg(BranchReg), .BranchAck(BranchAck),
        .FetchErr(FetchErr), .FetchCount(FetchCount), .RedirCount(RedirCount)
    );

    // Shared address adder that the sequencer steers.
    always_comb begin
        if (ResetPC)      ALout = 16'h0000;
        else if (PCplus1) ALout = PCside + 16'd1;
        else if (PCplusI) ALout = PCside + {8'h00, Iside};
        else if (Iplus0)  ALout = {8'h00, Iside};
        else if (Rplus0)  ALout = Rside;
        else              ALout = PCside;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] sel_for_mode(input logic [1:0] m);
        case (m)
            2'b00:   return 5'b00100;
            2'b01:   return 5'b00010;
            2'b10:   return 5'b00001;
            default: return 5'b01000;
        endcase
    endfunction

    function automatic logic [4:0] sels();
        return {ResetPC, PCplus1, PCplusI, Iplus0, Rplus0};
    endfunction

    task automatic wait_req();
        int k = 0;
        while (MemReq !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", 32'(MemReq), 32'd1);
        chk("mem_addr", 32'(MemAddr), 32'(exp_pc));
    endtask

    // Fetch at exp_pc; junk rvalid during the ack delay must be ignored.
    task automatic do_fetch(input int ack_dly, input int rv_dly, input logic [15:0] data);
        wait_req();
        chk("sel_idle_req", 32'(sels()), 32'd0);
        for (int i = 0; i < ack_dly; i++) begin
            MemRvalid = 1'b1;
            MemRdata  = 16'hDEAD ^ 16'(i);
            @(negedge clk);
            chk("addr_stable", 32'({MemReq, MemAddr}), 32'({1'b1, exp_pc}));
        end
        MemRvalid = 1'b0;
        MemAck    = 1'b1;
        @(negedge clk);
        MemAck    = 1'b0;
        BranchReq = 1'b1;
        #1;
        chk("wait_noreq", 32'(MemReq), 32'd0);
        chk("br_ignored", 32'(BranchAck), 32'd0);
        for (int i = 0; i < rv_dly; i++) @(negedge clk);
        BranchReq = 1'b0;
        MemRvalid = 1'b1;
        MemRdata  = data;
        @(negedge clk);
        MemRvalid = 1'b0;
        last_data = data;
        chk("instr_valid", 32'(InstrValid), 32'd1);
        chk("instr", 32'(Instr), 32'(data));
        chk("instr_pc", 32'(InstrPC), 32'(exp_pc));
    endtask

    task automatic finish_hold(input int stall, input bit br, input logic [1:0] mode,
                               input logic [7:0] imm, input logic [15:0] rg, input bit rdy);
        InstrReady = 1'b0;
        BranchReq  = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(InstrValid), 32'd1);
            chk("stall_noreq", 32'(MemReq), 32'd0);
            chk("stall_instr", 32'(Instr), 32'(last_data));
            chk("stall_ipc", 32'(InstrPC), 32'(exp_pc));
        end
        if (br) begin
            BranchReq  = 1'b1;
            BranchMode = mode;
            BranchImm  = imm;
            BranchReg  = rg;
            InstrReady = rdy;
            #1;
            chk("br_ack", 32'(BranchAck), 32'd1);
            chk("br_sel", 32'(sels()), 32'(sel_for_mode(mode)));
            case (mode)
                2'b00:   exp_pc = exp_pc + {8'h00, imm};
                2'b01:   exp_pc = {8'h00, imm};
                2'b10:   exp_pc = rg;
                default: exp_pc = exp_pc + 16'd1;
            endcase
            if (exp_rcnt != 16'hFFFF) exp_rcnt = exp_rcnt + 16'd1;
        end else begin
            InstrReady = 1'b1;
            #1;
            chk("acc_sel", 32'(sels()), 32'h08);
            chk("acc_noack", 32'(BranchAck), 32'd0);
            exp_pc = exp_pc + 16'd1;
        end
        if (exp_fcnt != 16'hFFFF) exp_fcnt = exp_fcnt + 16'd1;
        @(negedge clk);
        BranchReq  = 1'b0;
        InstrReady = 1'b0;
        chk("hold_left", 32'(InstrValid), 32'd0);
    endtask

    task automatic chk_perf();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", 32'(FetchCount), 32'(exp_fcnt));
        chk("redir_count", 32'(RedirCount), 32'(exp_rcnt));
`else
        chk("fetch_count", 32'(FetchCount), 32'd0);
        chk("redir_count", 32'(RedirCount), 32'd0);
`endif
    endtask

    initial begin
        MemAck = 1'b0; MemRvalid = 1'b0; MemRdata = 16'h0;
        InstrReady = 1'b0; BranchReq = 1'b0; BranchMode = 2'b00;
        BranchImm = 8'h00; BranchReg = 16'h0000;
        exp_pc = 16'h0000; last_data = 16'h0; exp_fcnt = 16'h0; exp_rcnt = 16'h0;

        // Reset state and release
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resetpc", 32'(ResetPC), 32'd1);
        chk("rst_outs", 32'({MemReq, InstrValid, BranchAck, FetchErr, PCplus1}), 32'd0);
        chk("rst_instr", 32'({Instr, InstrPC}), 32'd0);
        chk("rst_pc", 32'(PCside), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_resetpc", 32'(ResetPC), 32'd1);
        @(negedge clk);
        chk("rel_resetpc_drop", 32'(ResetPC), 32'd0);

        // Ideal memory sequential fetch 0000..0002
        for (int i = 0; i < 3; i++) begin
            do_fetch(0, 0, 16'hA000 + 16'(i));
            finish_hold(0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0);
        end

        // Redirect modes
        do_fetch(0, 0, 16'h1111); finish_hold(0, 1'b1, 2'b01, 8'h10, 16'h0000, 1'b0);
        do_fetch(0, 0, 16'h2222); finish_hold(0, 1'b1, 2'b00, 8'h05, 16'h0000, 1'b0);
        do_fetch(0, 0, 16'h3333); finish_hold(0, 1'b1, 2'b01, 8'h80, 16'h0000, 1'b0);
        do_fetch(0, 0, 16'h4444); finish_hold(0, 1'b1, 2'b10, 8'h00, 16'hBEEF, 1'b0);

        // Decoder stall for 5 cycles, then accept
        do_fetch(1, 2, 16'h5555); finish_hold(5, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0);

        // Memory timeout and re-issue of the same address
        wait_req();
        MemAck = 1'b1;
        @(negedge clk);
        MemAck = 1'b0;
        for (int i = 1; i <= TO; i++) begin
            chk("fetch_err", 32'(FetchErr), 32'(i == TO));
            chk("to_noreq", 32'(MemReq), 32'd0);
            if (i < TO) @(negedge clk);
        end
        @(negedge clk);
        chk("fetch_err_drop", 32'(FetchErr), 32'd0);
        do_fetch(2, 1, 16'h6666);
        finish_hold(0, 1'b1, 2'b11, 8'h00, 16'h0000, 1'b0);

        // Branch beats ready; then PC wrap FFFF -> 0000
        do_fetch(0, 0, 16'h7777); finish_hold(0, 1'b1, 2'b10, 8'h00, 16'hFFFF, 1'b1);
        do_fetch(0, 0, 16'h8888); finish_hold(0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0);
        chk("wrap_pc", 32'(exp_pc), 32'd0);
        do_fetch(0, 3, 16'h9999); finish_hold(1, 1'b1, 2'b00, 8'hFF, 16'h0000, 1'b1);
        chk_perf();

        // Reset asserted during WAIT; late rvalid must be discarded
        wait_req();
        MemAck = 1'b1;
        @(negedge clk);
        MemAck = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("midrst_resetpc", 32'(ResetPC), 32'd1);
        chk("midrst_outs", 32'({MemReq, InstrValid, FetchErr}), 32'd0);
        @(negedge clk);
        MemRvalid = 1'b1;
        MemRdata  = 16'h1234;
        @(negedge clk);
        MemRvalid = 1'b0;
        #1;
        chk("midrst_instr", 32'({Instr, InstrPC}), 32'd0);
        chk("midrst_valid", 32'(InstrValid), 32'd0);
        exp_pc = 16'h0000; exp_fcnt = 16'h0; exp_rcnt = 16'h0;
        chk_perf();
        rst_n = 1'b1;
        @(negedge clk);
        do_fetch(0, 0, 16'hCAFE); finish_hold(0, 1'b0, 2'b00, 8'h00, 16'h0000, 1'b0);

        // Randomized traffic against the PC model
        for (int n = 0; n < 40; n++) begin
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom));
            finish_hold(int'($urandom_range(0, 3)), 1'($urandom), 2'($urandom),
                        8'($urandom), 16'($urandom), 1'($urandom));
        end
        chk_perf();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
